// File: rtl/oled_console.sv
// oled_console: 4x16 character-terminal controller. Takes a byte stream,
// maintains the text buffer, cursor, contrast and cursor mode, handles the
// control codes, line wrap and auto-scroll. It also batches buffer changes into
// single redraw pulses for the downstream OLED interface.
module oled_console #(
  parameter int HOLDOFF  = 200,
  parameter int MAX_WAIT = 5000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   ch_data,
  input  logic         ch_valid,
  output logic         ch_ready,
  input  logic         clear_req,
  input  logic [7:0]   contrast_in,
  input  logic         contrast_we,
  input  logic [1:0]   cursor_mode,
  output logic         update,
  output logic [511:0] display_data,
  output logic [1:0]   line_count,
  output logic [7:0]   contrast,
  output logic         cursor_enable,
  output logic         cursor_flash,
  output logic [5:0]   cursor_pos
);

  localparam int QW = $clog2(HOLDOFF + 1);
  localparam int AW = $clog2(MAX_WAIT + 1);
  localparam logic [QW-1:0] QMAX = QW'(HOLDOFF);
  localparam logic [AW-1:0] AMAX = AW'(MAX_WAIT);
  localparam logic [7:0]    SP   = 8'h20;

  typedef enum logic [1:0] {IDLE, EXEC, SCROLL, CLEAR} state_t;

  state_t          state, state_nxt;
  logic [7:0]      byte_q, byte_nxt;
  logic [6:0]      clr_cnt, clr_nxt;
  logic [511:0]    disp_nxt;
  logic [5:0]      pos_nxt;
  logic            dirty, dirty_nxt;
  logic [QW-1:0]   quiet, quiet_nxt;
  logic [AW-1:0]   age, age_nxt;
  logic            evt, fire;

  // Bit offset of the LSB of cell p; cell 0 sits in the top byte.
  function automatic logic [8:0] cell_lsb(input logic [5:0] p);
    return {6'd63 - p, 3'b000};
  endfunction

  // Quiet counter saturates at HOLDOFF, so an update deferred by a busy
  // state still fires once the controller returns to IDLE.
  function automatic logic [QW-1:0] sat_quiet(input logic [QW-1:0] v);
    return (v == QMAX) ? v : v + QW'(1);
  endfunction

  function automatic logic [AW-1:0] sat_age(input logic [AW-1:0] v);
    return (v == AMAX) ? v : v + AW'(1);
  endfunction

  assign ch_ready   = (state == IDLE) && !clear_req && !rst;
  assign line_count = 2'b11;

  // Next-state, buffer and cursor decode for the terminal FSM.
  always_comb begin
    state_nxt = state;
    byte_nxt  = byte_q;
    clr_nxt   = clr_cnt;
    disp_nxt  = display_data;
    pos_nxt   = cursor_pos;
    case (state)
      IDLE: begin
        if (clear_req) begin
          state_nxt = CLEAR;
          clr_nxt   = '0;
        end else if (ch_valid) begin
          byte_nxt  = ch_data;
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        state_nxt = IDLE;
        if (byte_q >= 8'h20 && byte_q <= 8'h7E) begin
          disp_nxt[cell_lsb(cursor_pos) +: 8] = byte_q;
          if (cursor_pos == 6'd63) state_nxt = SCROLL;
          else                     pos_nxt   = cursor_pos + 6'd1;
        end else begin
          case (byte_q)
            8'h0A: begin
              if (cursor_pos[5:4] == 2'd3) state_nxt = SCROLL;
              else pos_nxt = {cursor_pos[5:4] + 2'd1, 4'd0};
            end
            8'h0D: pos_nxt = {cursor_pos[5:4], 4'd0};
            8'h08: begin
              if (cursor_pos != 6'd0) begin
                pos_nxt = cursor_pos - 6'd1;
                disp_nxt[cell_lsb(cursor_pos - 6'd1) +: 8] = SP;
              end
            end
            8'h0C: begin
              state_nxt = CLEAR;
              clr_nxt   = '0;
            end
            default: ;
          endcase
        end
      end
      SCROLL: begin
        disp_nxt  = {display_data[383:0], {16{SP}}};
        pos_nxt   = 6'd48;
        state_nxt = IDLE;
      end
      CLEAR: begin
        if (clr_cnt[6]) begin
          pos_nxt   = 6'd0;
          state_nxt = IDLE;
        end else begin
          disp_nxt[cell_lsb(clr_cnt[5:0]) +: 8] = SP;
          clr_nxt = clr_cnt + 7'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Change detection and update batching: quiet restarts on every change,
  // age runs from the first unflushed change.
  always_comb begin
    evt = (disp_nxt != display_data) || (pos_nxt != cursor_pos) ||
          (cursor_mode != {cursor_enable, cursor_flash});
    fire = dirty && (state == IDLE) && ((quiet == QMAX) || (age >= AMAX));
    dirty_nxt = dirty;
    quiet_nxt = quiet;
    age_nxt   = age;
    if (fire) begin
      dirty_nxt = evt;
      quiet_nxt = '0;
      age_nxt   = '0;
    end else if (evt) begin
      dirty_nxt = 1'b1;
      quiet_nxt = '0;
      age_nxt   = dirty ? sat_age(age) : '0;
    end else if (dirty) begin
      quiet_nxt = sat_quiet(quiet);
      age_nxt   = sat_age(age);
    end
  end

  // FSM, text buffer and cursor registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      byte_q       <= 8'h00;
      clr_cnt      <= '0;
      display_data <= {64{SP}};
      cursor_pos   <= 6'd0;
    end else begin
      state        <= state_nxt;
      byte_q       <= byte_nxt;
      clr_cnt      <= clr_nxt;
      display_data <= disp_nxt;
      cursor_pos   <= pos_nxt;
    end
  end

  // Dirty flag, batching counters and the registered update pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dirty  <= 1'b0;
      quiet  <= '0;
      age    <= '0;
      update <= 1'b0;
    end else begin
      dirty  <= dirty_nxt;
      quiet  <= quiet_nxt;
      age    <= age_nxt;
      update <= fire;
    end
  end

  // Contrast and cursor-mode registers, loaded in any FSM state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      contrast      <= 8'h7F;
      cursor_enable <= 1'b0;
      cursor_flash  <= 1'b0;
    end else begin
      if (contrast_we) contrast <= contrast_in;
      cursor_enable <= cursor_mode[1];
      cursor_flash  <= cursor_mode[0];
    end
  end

endmodule
